// File: rtl/periph_demux_pkg.sv
// periph_demux_pkg: shared types, OBI structs and width helpers for the peripheral demux.
package periph_demux_pkg;
    typedef enum logic {ARB_FIXED, ARB_RR} arb_mode_e;
    typedef struct packed {
        bit UseRReady;
        bit Integrity;
    } obi_cfg_t;
    localparam obi_cfg_t ObiDefaultConfig = '{UseRReady: 1'b1, Integrity: 1'b0};
    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } obi_a_t;
    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } obi_r_t;
    typedef struct packed {
        logic   req;
        obi_a_t a;
        logic   rready;
    } periph_obi_req_t;
    typedef struct packed {
        logic   gnt;
        logic   rvalid;
        obi_r_t r;
    } periph_obi_rsp_t;
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/periph_mgr_tracker.sv
// periph_mgr_tracker: per-manager outstanding counter and last-handshake port.
module periph_mgr_tracker
    import periph_demux_pkg::*;
#(
    parameter int NumMaxTrans = 4,
    parameter int SelW        = 1,
    localparam int CntW       = cnt_width(NumMaxTrans)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            i_hs,
    input  logic            i_down,
    input  logic [SelW-1:0] i_sel,
    output logic [CntW-1:0] o_in_flight,
    output logic [SelW-1:0] o_sel_q,
    output logic            o_full,
    output logic            o_may_switch
);
    logic [CntW-1:0] r_in_flight;
    logic [SelW-1:0] r_sel_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_in_flight <= '0;
            r_sel_q     <= '0;
        end else begin
            if (i_hs && !i_down) r_in_flight <= r_in_flight + 1'b1;
            else if (i_down && !i_hs) r_in_flight <= r_in_flight - 1'b1;
            if (i_hs) r_sel_q <= i_sel;
        end
    end
    assign o_in_flight  = r_in_flight;
    assign o_sel_q      = r_sel_q;
    assign o_full       = r_in_flight == CntW'(NumMaxTrans);
    // the last outstanding response retiring this cycle frees the manager to retarget now
    assign o_may_switch = (r_in_flight == '0) || (r_in_flight == CntW'(1) && i_down);
endmodule

// File: rtl/periph_multi_demux.sv
// periph_multi_demux: N-manager to M-subordinate OBI demux with per-port ownership
// so each subordinate serves one manager at a time and responses route unambiguously.
module periph_multi_demux
    import periph_demux_pkg::*;
#(
    parameter obi_cfg_t  ObiCfg      = ObiDefaultConfig,
    parameter type       obi_req_t   = periph_obi_req_t,
    parameter type       obi_rsp_t   = periph_obi_rsp_t,
    parameter int        NumMgrPorts = 2,
    parameter int        NumSbrPorts = 2,
    parameter int        NumMaxTrans = 4,
    parameter arb_mode_e ArbMode     = ARB_RR,
    parameter type       select_t    = logic [idx_width(NumSbrPorts)-1:0]
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [NumMgrPorts-1:0] mgr_active_i,
    input  select_t                mgr_select_i [NumMgrPorts],
    input  obi_req_t               mgr_req_i    [NumMgrPorts],
    output obi_rsp_t               mgr_rsp_o    [NumMgrPorts],
    output obi_req_t               sbr_req_o    [NumSbrPorts],
    input  obi_rsp_t               sbr_rsp_i    [NumSbrPorts]
);
    localparam int CntW = cnt_width(NumMaxTrans);
    localparam int MgrW = idx_width(NumMgrPorts);
    localparam int SelW = $bits(select_t);

    logic [CntW-1:0]        w_in_flight [NumMgrPorts];
    select_t                w_sel_q     [NumMgrPorts];
    logic [NumMgrPorts-1:0] w_full, w_may_switch, w_busy, w_rready, w_down, w_elig, w_won;
    logic [NumSbrPorts-1:0] w_win_vld;
    logic [MgrW-1:0]        w_win    [NumSbrPorts];
    logic [MgrW-1:0]        r_rr_ptr [NumSbrPorts];

    if (ObiCfg.Integrity) begin : g_integrity
        $fatal(1, "periph_multi_demux: OBI integrity signals are not supported");
    end

    for (genvar m = 0; m < NumMgrPorts; m++) begin : g_mgr
        assign w_busy[m]   = w_in_flight[m] != '0;
        assign w_rready[m] = ObiCfg.UseRReady ? mgr_req_i[m].rready : 1'b1;
        assign w_down[m]   = w_busy[m] & sbr_rsp_i[w_sel_q[m]].rvalid & w_rready[m];
        assign w_won[m]    = w_win_vld[mgr_select_i[m]] & (int'(w_win[mgr_select_i[m]]) == m);
        periph_mgr_tracker #(.NumMaxTrans(NumMaxTrans), .SelW(SelW)) u_trk (
            .clk_i        (clk_i),
            .rst_ni       (rst_ni),
            .i_hs         (w_won[m] & sbr_rsp_i[mgr_select_i[m]].gnt),
            .i_down       (w_down[m]),
            .i_sel        (mgr_select_i[m]),
            .o_in_flight  (w_in_flight[m]),
            .o_sel_q      (w_sel_q[m]),
            .o_full       (w_full[m]),
            .o_may_switch (w_may_switch[m])
        );
    end

    function automatic logic [MgrW-1:0] cand(input int ptr, input int i);
        return ArbMode == ARB_RR ? MgrW'((ptr + i) % NumMgrPorts) : MgrW'(i);
    endfunction

    // a port stays locked to its owner until the owner's count has reached zero in a prior cycle
    always_comb begin
        for (int m = 0; m < NumMgrPorts; m++) begin
            w_elig[m] = rst_ni & mgr_active_i[m] & mgr_req_i[m].req & ~w_full[m] &
                        ((mgr_select_i[m] == w_sel_q[m]) | w_may_switch[m]);
            for (int k = 0; k < NumMgrPorts; k++)
                if (k != m && w_busy[k] && w_sel_q[k] == mgr_select_i[m]) w_elig[m] = 1'b0;
        end
    end

    always_comb begin
        for (int p = 0; p < NumSbrPorts; p++) begin
            w_win_vld[p] = 1'b0;
            w_win[p]     = '0;
            for (int i = 0; i < NumMgrPorts; i++)
                if (!w_win_vld[p] && w_elig[cand(int'(r_rr_ptr[p]), i)] &&
                    int'(mgr_select_i[cand(int'(r_rr_ptr[p]), i)]) == p) begin
                    w_win_vld[p] = 1'b1;
                    w_win[p]     = cand(int'(r_rr_ptr[p]), i);
                end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int p = 0; p < NumSbrPorts; p++) r_rr_ptr[p] <= '0;
        end else begin
            for (int p = 0; p < NumSbrPorts; p++)
                if (w_win_vld[p] && sbr_rsp_i[p].gnt)
                    r_rr_ptr[p] <= (int'(w_win[p]) == NumMgrPorts - 1) ? '0 : w_win[p] + 1'b1;
        end
    end

    always_comb begin
        for (int p = 0; p < NumSbrPorts; p++) begin
            sbr_req_o[p]        = '0;
            sbr_req_o[p].rready = 1'b1;
            if (w_win_vld[p]) begin
                sbr_req_o[p].req = 1'b1;
                sbr_req_o[p].a   = mgr_req_i[w_win[p]].a;
            end
            for (int m = 0; m < NumMgrPorts; m++)
                if (w_busy[m] && int'(w_sel_q[m]) == p) sbr_req_o[p].rready = w_rready[m];
        end
    end

    always_comb begin
        for (int m = 0; m < NumMgrPorts; m++) begin
            mgr_rsp_o[m]        = '0;
            mgr_rsp_o[m].gnt    = w_won[m] & sbr_rsp_i[mgr_select_i[m]].gnt;
            mgr_rsp_o[m].rvalid = rst_ni & w_busy[m] & sbr_rsp_i[w_sel_q[m]].rvalid;
            mgr_rsp_o[m].r      = sbr_rsp_i[w_sel_q[m]].r;
        end
    end
endmodule

// File: tb/tb_periph_multi_demux.sv
// tb_periph_multi_demux: directed checks of the demux plus a scoreboarded random phase.
module tb_periph_multi_demux;
    import periph_demux_pkg::*;
    localparam int NM = 3;
    localparam int NS = 4;
    localparam int NT = 4;
    localparam obi_cfg_t Cfg = '{UseRReady: 1'b1, Integrity: 1'b0};

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [NM-1:0]   act;
    logic [1:0]      sel     [NM];
    periph_obi_req_t mreq    [NM];
    periph_obi_rsp_t mrsp    [NM];
    periph_obi_rsp_t mrsp_fx [NM];
    periph_obi_req_t sreq    [NS];
    periph_obi_req_t sreq_fx [NS];
    periph_obi_rsp_t srsp    [NS];
    int n_cmp = 0;
    int n_err = 0;

    periph_multi_demux #(.ObiCfg(Cfg), .NumMgrPorts(NM), .NumSbrPorts(NS), .NumMaxTrans(NT),
                         .ArbMode(ARB_RR)) u_rr (
        .clk_i(clk), .rst_ni(rst_n), .mgr_active_i(act), .mgr_select_i(sel),
        .mgr_req_i(mreq), .mgr_rsp_o(mrsp), .sbr_req_o(sreq), .sbr_rsp_i(srsp));

    periph_multi_demux #(.ObiCfg(Cfg), .NumMgrPorts(NM), .NumSbrPorts(NS), .NumMaxTrans(NT),
                         .ArbMode(ARB_FIXED)) u_fx (
        .clk_i(clk), .rst_ni(rst_n), .mgr_active_i(act), .mgr_select_i(sel),
        .mgr_req_i(mreq), .mgr_rsp_o(mrsp_fx), .sbr_req_o(sreq_fx), .sbr_rsp_i(srsp));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        for (int m = 0; m < NM; m++) begin
            mreq[m]        = '0;
            mreq[m].rready = 1'b1;
        end
        for (int p = 0; p < NS; p++) srsp[p] = '0;
    endtask

    function automatic logic [2:0] gv();
        return {mrsp[2].gnt, mrsp[1].gnt, mrsp[0].gnt};
    endfunction
    function automatic logic [2:0] gvf();
        return {mrsp_fx[2].gnt, mrsp_fx[1].gnt, mrsp_fx[0].gnt};
    endfunction
    function automatic logic [2:0] rv();
        return {mrsp[2].rvalid, mrsp[1].rvalid, mrsp[0].rvalid};
    endfunction

    logic [2:0]  exp_rr [4];
    logic [31:0] mq     [NM][$];
    logic [31:0] pq     [NS][$];
    int          cnt    [NM];
    logic [1:0]  lastp  [NM];
    logic        done   [NM];

    initial begin
        rst_n = 1'b0;
        act   = '1;
        idle();
        for (int m = 0; m < NM; m++) sel[m] = 2'd0;
        repeat (2) tick();
        // outputs held quiet while in reset
        mreq[0].req = 1'b1;
        srsp[0].gnt = 1'b1;
        for (int p = 0; p < NS; p++) srsp[p].rvalid = 1'b1;
        #2;
        chk("rst_sreq", sreq[0].req, 1'b0);
        chk("rst_gnt", gv(), 3'b000);
        chk("rst_rvalid", rv(), 3'b000);
        tick();
        idle();
        rst_n = 1'b1;
        tick();

        // single manager fills NumMaxTrans on port 1, then stalls until a response
        sel[0]      = 2'd1;
        srsp[1].gnt = 1'b1;
        mreq[0].req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            mreq[0].a.addr = 32'h100 + i;
            #2;
            chk("t1_gnt", mrsp[0].gnt, 1'b1);
            chk("t1_addr", sreq[1].a.addr, 32'h100 + i);
            tick();
        end
        #2;
        chk("t1_full_gnt", mrsp[0].gnt, 1'b0);
        chk("t1_full_req", sreq[1].req, 1'b0);
        tick();
        srsp[1].rvalid  = 1'b1;
        srsp[1].r.rdata = 32'hA0;
        #2;
        chk("t1_rv", mrsp[0].rvalid, 1'b1);
        chk("t1_rdata", mrsp[0].r.rdata, 32'hA0);
        chk("t1_nobypass", mrsp[0].gnt, 1'b0);
        tick();
        srsp[1].rvalid = 1'b0;
        mreq[0].a.addr = 32'h104;
        #2;
        chk("t1_regnt", mrsp[0].gnt, 1'b1);
        tick();
        mreq[0].req    = 1'b0;
        srsp[1].rvalid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            srsp[1].r.rdata = 32'hA1 + i;
            #2;
            chk("t1_drain_rv", mrsp[0].rvalid, 1'b1);
            chk("t1_drain_rdata", mrsp[0].r.rdata, 32'hA1 + i);
            tick();
        end
        #2;
        chk("t1_idle_rv", mrsp[0].rvalid, 1'b0);
        tick();
        idle();

        // manager 1 waits for manager 0 to release port 2, plus one bubble
        sel[0]      = 2'd2;
        srsp[2].gnt = 1'b1;
        mreq[0].req = 1'b1;
        repeat (2) begin
            #2;
            chk("t2_m0_gnt", mrsp[0].gnt, 1'b1);
            tick();
        end
        mreq[0].req    = 1'b0;
        sel[1]         = 2'd2;
        mreq[1].req    = 1'b1;
        mreq[1].a.addr = 32'h200;
        #2;
        chk("t2_lock0", mrsp[1].gnt, 1'b0);
        chk("t2_lock_req", sreq[2].req, 1'b0);
        tick();
        srsp[2].rvalid = 1'b1;
        #2;
        chk("t2_lock1", mrsp[1].gnt, 1'b0);
        chk("t2_m0_rv", mrsp[0].rvalid, 1'b1);
        tick();
        #2;
        chk("t2_lock2", mrsp[1].gnt, 1'b0);
        chk("t2_m0_rv_last", mrsp[0].rvalid, 1'b1);
        tick();
        srsp[2].rvalid = 1'b0;
        #2;
        chk("t2_handover", mrsp[1].gnt, 1'b1);
        chk("t2_addr", sreq[2].a.addr, 32'h200);
        tick();
        mreq[1].req     = 1'b0;
        srsp[2].rvalid  = 1'b1;
        srsp[2].r.rdata = 32'hB0;
        #2;
        chk("t2_m1_rv", mrsp[1].rvalid, 1'b1);
        chk("t2_m0_quiet", mrsp[0].rvalid, 1'b0);
        tick();
        idle();

        // arbitration: grants on even cycles, responses on odd cycles
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        exp_rr[0] = 3'b001;
        exp_rr[1] = 3'b010;
        exp_rr[2] = 3'b100;
        exp_rr[3] = 3'b001;
        for (int m = 0; m < NM; m++) begin
            mreq[m].req    = 1'b1;
            sel[m]         = 2'd0;
            mreq[m].a.addr = 32'(m);
        end
        for (int i = 0; i < 8; i++) begin
            srsp[0].gnt    = (i % 2 == 0);
            srsp[0].rvalid = (i % 2 == 1);
            #2;
            if (i % 2 == 0) begin
                chk("t3_rr_gnt", gv(), exp_rr[i/2]);
                chk("t3_fixed_gnt", gvf(), 3'b001);
            end else begin
                chk("t3_rr_rv", rv(), exp_rr[i/2]);
            end
            tick();
        end
        idle();

        // retarget in the same cycle the single outstanding response returns
        sel[0]      = 2'd1;
        mreq[0].req = 1'b1;
        srsp[1].gnt = 1'b1;
        srsp[3].gnt = 1'b1;
        #2;
        chk("t4_first", mrsp[0].gnt, 1'b1);
        tick();
        sel[0] = 2'd3;
        #2;
        chk("t4_hold", mrsp[0].gnt, 1'b0);
        tick();
        srsp[1].rvalid = 1'b1;
        #2;
        chk("t4_switch_gnt", mrsp[0].gnt, 1'b1);
        chk("t4_switch_req", sreq[3].req, 1'b1);
        chk("t4_rv", mrsp[0].rvalid, 1'b1);
        tick();
        mreq[0].req     = 1'b0;
        srsp[1].rvalid  = 1'b0;
        srsp[3].rvalid  = 1'b1;
        srsp[3].r.rdata = 32'hC3;
        #2;
        chk("t4_rv3", mrsp[0].rvalid, 1'b1);
        chk("t4_rdata3", mrsp[0].r.rdata, 32'hC3);
        tick();
        idle();

        // inactive manager issues nothing but still drains
        sel[0]      = 2'd0;
        mreq[0].req = 1'b1;
        srsp[0].gnt = 1'b1;
        #2;
        chk("t5_gnt", mrsp[0].gnt, 1'b1);
        tick();
        act[0] = 1'b0;
        #2;
        chk("t5_inactive", mrsp[0].gnt, 1'b0);
        tick();
        srsp[0].rvalid = 1'b1;
        #2;
        chk("t5_drain", mrsp[0].rvalid, 1'b1);
        tick();
        idle();
        act = '1;

        // reset with three outstanding
        sel[0]      = 2'd2;
        mreq[0].req = 1'b1;
        srsp[2].gnt = 1'b1;
        repeat (3) tick();
        rst_n          = 1'b0;
        srsp[2].rvalid = 1'b1;
        #2;
        chk("t6_rst_gnt", mrsp[0].gnt, 1'b0);
        chk("t6_rst_rv", mrsp[0].rvalid, 1'b0);
        chk("t6_rst_req", sreq[2].req, 1'b0);
        tick();
        rst_n       = 1'b1;
        mreq[0].req = 1'b0;
        #2;
        chk("t6_stale", mrsp[0].rvalid, 1'b0);
        tick();
        mreq[0].req    = 1'b1;
        srsp[2].rvalid = 1'b0;
        #2;
        chk("t6_after", mrsp[0].gnt, 1'b1);
        tick();
        mreq[0].req    = 1'b0;
        srsp[2].rvalid = 1'b1;
        tick();
        idle();

        // random traffic: 3 managers x 4 ports, in-order subordinates
        for (int m = 0; m < NM; m++) begin
            cnt[m]   = 0;
            lastp[m] = 2'd0;
        end
        for (int cyc = 0, seq = 0; cyc < 3000; cyc++) begin
            for (int m = 0; m < NM; m++) begin
                if (!mreq[m].req && cyc < 2000 && $urandom_range(1, 0) == 1) begin
                    mreq[m].req    = 1'b1;
                    sel[m]         = 2'($urandom_range(3, 0));
                    mreq[m].a.addr = 32'((m << 24) | seq);
                    seq++;
                end
                mreq[m].rready = $urandom_range(3, 0) != 0;
                done[m]        = 1'b0;
            end
            for (int p = 0; p < NS; p++) begin
                srsp[p].gnt     = $urandom_range(3, 0) != 0;
                srsp[p].rvalid  = pq[p].size() != 0 && $urandom_range(1, 0) == 1;
                srsp[p].r.rdata = pq[p].size() != 0 ? pq[p][0] : 32'h0;
            end
            #2;
            for (int p = 0; p < NS; p++) begin
                if (srsp[p].rvalid && sreq[p].rready) void'(pq[p].pop_front());
                if (sreq[p].req && srsp[p].gnt) pq[p].push_back(sreq[p].a.addr);
            end
            for (int m = 0; m < NM; m++) begin
                if (mrsp[m].rvalid && mreq[m].rready) begin
                    chk("rnd_rv_expected", mq[m].size() != 0, 1'b1);
                    if (mq[m].size() != 0) begin
                        chk("rnd_order", mrsp[m].r.rdata, mq[m].pop_front());
                        cnt[m]--;
                    end
                end
                if (mreq[m].req && mrsp[m].gnt) begin
                    mq[m].push_back(mreq[m].a.addr);
                    cnt[m]++;
                    lastp[m] = sel[m];
                    done[m]  = 1'b1;
                end
            end
            begin
                logic shared;
                shared = 1'b0;
                for (int m = 0; m < NM; m++)
                    for (int k = m + 1; k < NM; k++)
                        if (cnt[m] > 0 && cnt[k] > 0 && lastp[m] == lastp[k]) shared = 1'b1;
                chk("rnd_port_shared", shared, 1'b0);
            end
            tick();
            for (int m = 0; m < NM; m++) if (done[m]) mreq[m].req = 1'b0;
        end
        for (int m = 0; m < NM; m++) chk("rnd_drained", mq[m].size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
